// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: widths, the data-cache control bus
// and funct3 load/store encodings.
package mem_stage_pkg;

   localparam int DataSize    = 32;
   localparam int RegAddrSize = 5;

   typedef struct packed {
      logic       read;
      logic       write;
      logic [2:0] funct3;
   } DataCacheControlBus;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // funct3[1:0] is the access size for loads and stores alike
   function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                          input logic [2:0] funct3);
      logic mis;
      case (funct3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = addr_lo[0];
         default: mis = |addr_lo;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core and a word-wide data memory: store
// replication with byte enables, and load lane extraction with extension.
module mem_lane_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DataSize
)(
   input  logic [1:0]        addr_lo_i,
   input  logic [2:0]        funct3_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [3:0]        byte_en_o,
   output logic [DATA_W-1:0] load_data_o
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Stores replicate the datum across the word; byte enables pick the lane
   always_comb begin
      wdata_o   = store_data_i;
      byte_en_o = 4'b1111;
      case (funct3_i[1:0])
         2'b00: begin
            wdata_o   = {(DATA_W/8){store_data_i[7:0]}};
            byte_en_o = 4'b0001 << addr_lo_i;
         end
         2'b01: begin
            wdata_o   = {(DATA_W/16){store_data_i[15:0]}};
            byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      lane_byte = rdata_i[7:0];
      case (addr_lo_i)
         2'd1:    lane_byte = rdata_i[15:8];
         2'd2:    lane_byte = rdata_i[23:16];
         2'd3:    lane_byte = rdata_i[31:24];
         default: ;
      endcase
      lane_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      load_data_o = rdata_i;
      case (funct3_i)
         F3_LB:   load_data_o = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
         F3_LBU:  load_data_o = {{(DATA_W-8){1'b0}}, lane_byte};
         F3_LH:   load_data_o = {{(DATA_W-16){lane_half[15]}}, lane_half};
         F3_LHU:  load_data_o = {{(DATA_W-16){1'b0}}, lane_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through in one cycle and runs loads
// and stores against a single-request data memory, stalling upstream meanwhile.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DataSize,
   parameter int REG_AW = RegAddrSize
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              validIn,
   input  logic [DATA_W-1:0] aluResultIn,
   input  logic [DATA_W-1:0] storeDataIn,
   input  logic [4:0]        dataCacheControlIn,
   input  logic [REG_AW-1:0] writeBackAddrIn,
   input  logic              writeEnableIn,
   output logic              memReq,
   output logic              memWe,
   output logic [DATA_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   output logic [3:0]        memByteEn,
   input  logic              memAck,
   input  logic [DATA_W-1:0] memRData,
   output logic              stallOut,
   output logic              validOut,
   output logic              writeEnableOut,
   output logic [REG_AW-1:0] writeBackAddrOut,
   output logic [DATA_W-1:0] writeBackData,
   output logic              misalignOut,
   output logic [1:0]        dbgStateOut
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  sdata_q, sdata_d;
   logic [2:0]         funct3_q, funct3_d;
   logic               store_q, store_d;
   logic [REG_AW-1:0]  rd_q, rd_d;
   logic               rd_we_q, rd_we_d;

   logic               valid_q, valid_d;
   logic               wen_q, wen_d;
   logic [REG_AW-1:0]  wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0]  wb_data_q, wb_data_d;
   logic               misalign_q, misalign_d;

   DataCacheControlBus ctrl_in;
   logic               mem_op;
   logic [DATA_W-1:0]  load_data;

   assign ctrl_in = dataCacheControlIn;
   assign mem_op  = ctrl_in.read | ctrl_in.write;

   mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
      .addr_lo_i    (addr_q[1:0]),
      .funct3_i     (funct3_q),
      .store_data_i (sdata_q),
      .rdata_i      (memRData),
      .wdata_o      (memWData),
      .byte_en_o    (memByteEn),
      .load_data_o  (load_data)
   );

   // Transaction fields are latched once at acceptance, so memory-side
   // outputs stay stable for the whole request regardless of upstream.
   assign memReq  = (state_q == REQ);
   assign memWe   = (state_q == REQ) & store_q;
   assign memAddr = {addr_q[DATA_W-1:2], 2'b00};

   assign validOut         = valid_q;
   assign writeEnableOut   = wen_q;
   assign writeBackAddrOut = wb_addr_q;
   assign writeBackData    = wb_data_q;
   assign misalignOut      = misalign_q;
   assign dbgStateOut      = state_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      funct3_d   = funct3_q;
      store_d    = store_q;
      rd_d       = rd_q;
      rd_we_d    = rd_we_q;
      valid_d    = 1'b0;
      wen_d      = 1'b0;
      misalign_d = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      stallOut   = 1'b0;

      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (validIn) begin
               if (!mem_op) begin
                  valid_d   = 1'b1;
                  wen_d     = writeEnableIn & (writeBackAddrIn != '0);
                  wb_addr_d = writeBackAddrIn;
                  wb_data_d = aluResultIn;
               end else if (is_misaligned(aluResultIn[1:0], ctrl_in.funct3)) begin
                  valid_d    = 1'b1;
                  misalign_d = 1'b1;
                  wb_addr_d  = writeBackAddrIn;
                  wb_data_d  = aluResultIn;
               end else begin
                  state_d  = REQ;
                  stallOut = 1'b1;
                  addr_d   = aluResultIn;
                  sdata_d  = storeDataIn;
                  funct3_d = ctrl_in.funct3;
                  store_d  = ctrl_in.write;
                  rd_d     = writeBackAddrIn;
                  rd_we_d  = writeEnableIn;
               end
            end
         end
         REQ: begin
            stallOut = 1'b1;
            if (memAck) begin
               state_d   = RESP;
               valid_d   = 1'b1;
               wb_addr_d = rd_q;
               if (!store_q) begin
                  wb_data_d = load_data;
                  wen_d     = rd_we_q & (rd_q != '0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         sdata_q    <= '0;
         funct3_q   <= '0;
         store_q    <= 1'b0;
         rd_q       <= '0;
         rd_we_q    <= 1'b0;
         valid_q    <= 1'b0;
         wen_q      <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         funct3_q   <= funct3_d;
         store_q    <= store_d;
         rd_q       <= rd_d;
         rd_we_q    <= rd_we_d;
         valid_q    <= valid_d;
         wen_q      <= wen_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single transactions plus
// hand-written sequences for wait states, back-to-back results and reset.
module tb_mem_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          validIn;
   logic [DW-1:0] aluResultIn;
   logic [DW-1:0] storeDataIn;
   logic [4:0]    dataCacheControlIn;
   logic [AW-1:0] writeBackAddrIn;
   logic          writeEnableIn;
   logic          memReq;
   logic          memWe;
   logic [DW-1:0] memAddr;
   logic [DW-1:0] memWData;
   logic [3:0]    memByteEn;
   logic          memAck;
   logic [DW-1:0] memRData;
   logic          stallOut;
   logic          validOut;
   logic          writeEnableOut;
   logic [AW-1:0] writeBackAddrOut;
   logic [DW-1:0] writeBackData;
   logic          misalignOut;
   logic [1:0]    dbgStateOut;

   mem_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk                (clk),
      .reset              (reset),
      .validIn            (validIn),
      .aluResultIn        (aluResultIn),
      .storeDataIn        (storeDataIn),
      .dataCacheControlIn (dataCacheControlIn),
      .writeBackAddrIn    (writeBackAddrIn),
      .writeEnableIn      (writeEnableIn),
      .memReq             (memReq),
      .memWe              (memWe),
      .memAddr            (memAddr),
      .memWData           (memWData),
      .memByteEn          (memByteEn),
      .memAck             (memAck),
      .memRData           (memRData),
      .stallOut           (stallOut),
      .validOut           (validOut),
      .writeEnableOut     (writeEnableOut),
      .writeBackAddrOut   (writeBackAddrOut),
      .writeBackData      (writeBackData),
      .misalignOut        (misalignOut),
      .dbgStateOut        (dbgStateOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]    ctrl;
      logic [DW-1:0] alu;
      logic [DW-1:0] sdata;
      logic [AW-1:0] rd;
      logic          we_in;
      logic [DW-1:0] rdata;
      logic          mem;
      logic          store;
      logic [3:0]    be;
      logic [DW-1:0] wdata;
      logic [DW-1:0] wb;
      logic          chk_wb;
      logic          wen;
      logic          mis;
   } vec_t;

   vec_t          vecs[$];
   logic [DW-1:0] exp_q[$];
   int            total = 0;
   int            bad = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] ctrl, input logic [DW-1:0] alu,
                               input logic [DW-1:0] sdata, input logic [AW-1:0] rd,
                               input logic we_in, input logic [DW-1:0] rdata,
                               input logic mem, input logic store, input logic [3:0] be,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] wb,
                               input logic chk_wb, input logic wen, input logic mis);
      vec_t v;
      v.ctrl = ctrl; v.alu = alu; v.sdata = sdata; v.rd = rd; v.we_in = we_in;
      v.rdata = rdata; v.mem = mem; v.store = store; v.be = be; v.wdata = wdata;
      v.wb = wb; v.chk_wb = chk_wb; v.wen = wen; v.mis = mis;
      return v;
   endfunction

   task automatic idle_inputs();
      validIn            = 1'b0;
      aluResultIn        = '0;
      storeDataIn        = '0;
      dataCacheControlIn = '0;
      writeBackAddrIn    = '0;
      writeEnableIn      = 1'b0;
   endtask

   task automatic drive(input logic [4:0] ctrl, input logic [DW-1:0] alu,
                        input logic [DW-1:0] sdata, input logic [AW-1:0] rd, input logic we_in);
      validIn            = 1'b1;
      dataCacheControlIn = ctrl;
      aluResultIn        = alu;
      storeDataIn        = sdata;
      writeBackAddrIn    = rd;
      writeEnableIn      = we_in;
   endtask

   // One transaction; a memory access is acked in its first request cycle
   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      logic [DW-1:0] exp_addr;
      tag = $sformatf("vec%0d", idx);
      exp_addr = {v.alu[DW-1:2], 2'b00};
      @(negedge clk);
      drive(v.ctrl, v.alu, v.sdata, v.rd, v.we_in);
      #1 chk({tag, "_stall_accept"}, 32'(stallOut), 32'(v.mem));
      @(negedge clk);
      idle_inputs();
      if (v.mem) begin
         #1;
         chk({tag, "_memReq"}, 32'(memReq), 32'd1);
         chk({tag, "_memAddr"}, memAddr, exp_addr);
         chk({tag, "_memWe"}, 32'(memWe), 32'(v.store));
         if (v.store) begin
            chk({tag, "_memByteEn"}, 32'(memByteEn), 32'(v.be));
            chk({tag, "_memWData"}, memWData, v.wdata);
         end
         memAck   = 1'b1;
         memRData = v.rdata;
         @(negedge clk);
         memAck   = 1'b0;
         memRData = '0;
      end
      #1;
      chk({tag, "_validOut"}, 32'(validOut), 32'd1);
      chk({tag, "_wen"}, 32'(writeEnableOut), 32'(v.wen));
      chk({tag, "_misalign"}, 32'(misalignOut), 32'(v.mis));
      chk({tag, "_wbAddr"}, 32'(writeBackAddrOut), 32'(v.rd));
      chk({tag, "_stall_done"}, 32'(stallOut), 32'd0);
      chk({tag, "_memReq_done"}, 32'(memReq), 32'd0);
      if (v.chk_wb) chk({tag, "_wbData"}, writeBackData, v.wb);
      @(negedge clk);
      #1;
      chk({tag, "_validOut_drop"}, 32'(validOut), 32'd0);
      chk({tag, "_misalign_drop"}, 32'(misalignOut), 32'd0);
      chk({tag, "_wen_drop"}, 32'(writeEnableOut), 32'd0);
   endtask

   initial begin
      int stall_cnt;
      reset    = 1'b1;
      memAck   = 1'b0;
      memRData = '0;
      idle_inputs();

      //         ctrl      alu           sdata         rd     we  rdata        mem st be       wdata         wb            chk wen mis
      vecs.push_back(mk(5'b00000, 32'h0000_1234, 32'h0, 5'd5,  1, 32'h0,       0, 0, 4'b0000, 32'h0,        32'h0000_1234, 1, 1, 0));
      vecs.push_back(mk(5'b00000, 32'hDEAD_BEEF, 32'h0, 5'd0,  1, 32'h0,       0, 0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1, 0, 0));
      vecs.push_back(mk(5'b00000, 32'h0000_5555, 32'h0, 5'd7,  0, 32'h0,       0, 0, 4'b0000, 32'h0,        32'h0000_5555, 1, 0, 0));
      vecs.push_back(mk(5'b10000, 32'h0000_1003, 32'h0, 5'd3,  1, 32'h80FF_FFFF, 1, 0, 4'b0000, 32'h0,      32'hFFFF_FF80, 1, 1, 0));
      vecs.push_back(mk(5'b10100, 32'h0000_1003, 32'h0, 5'd3,  1, 32'h80FF_FFFF, 1, 0, 4'b0000, 32'h0,      32'h0000_0080, 1, 1, 0));
      vecs.push_back(mk(5'b10001, 32'h0000_1002, 32'h0, 5'd4,  1, 32'h8001_7FFF, 1, 0, 4'b0000, 32'h0,      32'hFFFF_8001, 1, 1, 0));
      vecs.push_back(mk(5'b10101, 32'h0000_1000, 32'h0, 5'd4,  1, 32'h8001_F00F, 1, 0, 4'b0000, 32'h0,      32'h0000_F00F, 1, 1, 0));
      vecs.push_back(mk(5'b10010, 32'h0000_3000, 32'h0, 5'd31, 1, 32'hCAFE_F00D, 1, 0, 4'b0000, 32'h0,      32'hCAFE_F00D, 1, 1, 0));
      vecs.push_back(mk(5'b10000, 32'h0000_1001, 32'h0, 5'd2,  1, 32'h1234_5678, 1, 0, 4'b0000, 32'h0,      32'h0000_0056, 1, 1, 0));
      vecs.push_back(mk(5'b10010, 32'h0000_3004, 32'h0, 5'd0,  1, 32'h1111_2222, 1, 0, 4'b0000, 32'h0,      32'h1111_2222, 1, 0, 0));
      vecs.push_back(mk(5'b01001, 32'h0000_2002, 32'h1111_ABCD, 5'd8, 1, 32'h0,  1, 1, 4'b1100, 32'hABCD_ABCD, 32'h0,       0, 0, 0));
      vecs.push_back(mk(5'b01001, 32'h0000_2000, 32'h0000_BEEF, 5'd8, 1, 32'h0,  1, 1, 4'b0011, 32'hBEEF_BEEF, 32'h0,       0, 0, 0));
      vecs.push_back(mk(5'b01000, 32'h0000_2001, 32'h1234_56EE, 5'd8, 1, 32'h0,  1, 1, 4'b0010, 32'hEEEE_EEEE, 32'h0,       0, 0, 0));
      vecs.push_back(mk(5'b01000, 32'h0000_2003, 32'h0000_0077, 5'd8, 1, 32'h0,  1, 1, 4'b1000, 32'h7777_7777, 32'h0,       0, 0, 0));
      vecs.push_back(mk(5'b01010, 32'h0000_2004, 32'h89AB_CDEF, 5'd8, 1, 32'h0,  1, 1, 4'b1111, 32'h89AB_CDEF, 32'h0,       0, 0, 0));
      vecs.push_back(mk(5'b11010, 32'h0000_2008, 32'h0102_0304, 5'd9, 1, 32'hFFFF_FFFF, 1, 1, 4'b1111, 32'h0102_0304, 32'h0, 0, 0, 0));
      vecs.push_back(mk(5'b10010, 32'h0000_3001, 32'h0, 5'd10, 1, 32'h0,       0, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 1));
      vecs.push_back(mk(5'b10001, 32'h0000_3003, 32'h0, 5'd10, 1, 32'h0,       0, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 1));
      vecs.push_back(mk(5'b01010, 32'h0000_3002, 32'h0, 5'd10, 1, 32'h0,       0, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 1));

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_validOut", 32'(validOut), 32'd0);
      chk("rst_wbData", writeBackData, 32'd0);
      chk("rst_stall", 32'(stallOut), 32'd0);
      chk("rst_memReq", 32'(memReq), 32'd0);
      chk("rst_state", 32'(dbgStateOut), 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // LB with the ack in the third request cycle; upstream churns meanwhile
      @(negedge clk);
      drive(5'b10000, 32'h0000_1003, 32'h0, 5'd6, 1'b1);
      stall_cnt = 0;
      #1 if (stallOut) stall_cnt++;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(5'b01010, 32'hFFFF_FFFC, 32'h5555_5555, 5'd1, 1'b1);
         #1;
         chk("wait_memReq", 32'(memReq), 32'd1);
         chk("wait_memAddr", memAddr, 32'h0000_1000);
         chk("wait_memWe", 32'(memWe), 32'd0);
         if (stallOut) stall_cnt++;
         if (c == 2) begin
            memAck   = 1'b1;
            memRData = 32'h80FF_FFFF;
         end
      end
      @(negedge clk);
      idle_inputs();
      memAck = 1'b0;
      #1;
      chk("wait_stall_cycles", 32'(stall_cnt), 32'd4);
      chk("wait_stall_resp", 32'(stallOut), 32'd0);
      chk("wait_validOut", 32'(validOut), 32'd1);
      chk("wait_wbData", writeBackData, 32'hFFFF_FF80);
      chk("wait_wen", 32'(writeEnableOut), 32'd1);
      chk("wait_wbAddr", 32'(writeBackAddrOut), 32'd6);

      // A stray ack while idle must do nothing
      @(negedge clk);
      memAck   = 1'b1;
      memRData = 32'h1234_5678;
      @(negedge clk);
      memAck = 1'b0;
      #1;
      chk("stray_ack_validOut", 32'(validOut), 32'd0);
      chk("stray_ack_state", 32'(dbgStateOut), 32'd0);
      chk("stray_ack_wbData", writeBackData, 32'hFFFF_FF80);

      // LW acked in its request cycle, then an ALU op presented during RESP
      @(negedge clk);
      drive(5'b10010, 32'h0000_3000, 32'h0, 5'd11, 1'b1);
      exp_q.push_back(32'hCAFE_BABE);
      exp_q.push_back(32'h0000_0077);
      @(negedge clk);
      idle_inputs();
      memAck   = 1'b1;
      memRData = 32'hCAFE_BABE;
      @(negedge clk);
      memAck = 1'b0;
      drive(5'b00000, 32'h0000_0077, 32'h0, 5'd12, 1'b1);
      #1;
      chk("b2b_stall_resp", 32'(stallOut), 32'd0);
      chk("b2b_valid0", 32'(validOut), 32'd1);
      chk("b2b_data0", writeBackData, exp_q.pop_front());
      chk("b2b_addr0", 32'(writeBackAddrOut), 32'd11);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("b2b_valid1", 32'(validOut), 32'd1);
      chk("b2b_data1", writeBackData, exp_q.pop_front());
      chk("b2b_addr1", 32'(writeBackAddrOut), 32'd12);
      @(negedge clk);
      #1 chk("b2b_valid_drop", 32'(validOut), 32'd0);

      // Reset while a request is outstanding, then a late ack
      @(negedge clk);
      drive(5'b10010, 32'h0000_3000, 32'h0, 5'd13, 1'b1);
      @(negedge clk);
      idle_inputs();
      #1 chk("rreq_memReq", 32'(memReq), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      memAck   = 1'b1;
      memRData = 32'hFFFF_FFFF;
      #1;
      chk("rreq_state", 32'(dbgStateOut), 32'd0);
      chk("rreq_memReq_off", 32'(memReq), 32'd0);
      chk("rreq_stall", 32'(stallOut), 32'd0);
      chk("rreq_wbData", writeBackData, 32'd0);
      chk("rreq_wbAddr", 32'(writeBackAddrOut), 32'd0);
      @(negedge clk);
      memAck = 1'b0;
      #1;
      chk("rreq_validOut", 32'(validOut), 32'd0);
      chk("rreq_wen", 32'(writeEnableOut), 32'd0);
      chk("rreq_misalign", 32'(misalignOut), 32'd0);
      chk("rreq_wbData_after", writeBackData, 32'd0);
      chk("rreq_state_after", 32'(dbgStateOut), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath and address width.
REQ-002 Parameter: REG_AW, 5, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 validIn  input  1  ALU stage presents an instruction this cycle.
REQ-006 aluResultIn  input  DATA_W  ALU result; the effective address for loads/stores.
REQ-007 storeDataIn  input  DATA_W  rs2 data for stores.
REQ-008 dataCacheControlIn  input  5  [4]=read, [3]=write, [2:0]=funct3 size/sign.
REQ-009 writeBackAddrIn / writeEnableIn  input  REG_AW / 1  destination register and its write enable.
REQ-010 memReq / memWe  output  1 / 1  data-memory request and write strobe.
REQ-011 memAddr / memWData / memByteEn  output  DATA_W / DATA_W / 4  word-aligned address, lane-shifted store data, byte enables.
REQ-012 memAck / memRData  input  1 / DATA_W  memory completion and read word, valid in the same cycle as memAck.
REQ-013 stallOut  output  1  freezes all upstream stages while high.
REQ-014 validOut / writeEnableOut / writeBackAddrOut / writeBackData  output  1 / 1 / REG_AW / DATA_W  MEM/WB register.
REQ-015 misalignOut  output  1  one-cycle pulse for a misaligned access.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ and RESP.
REQ-017 IDLE, validIn=1, read=0 and write=0: the ALU result SHALL appear on writeBackData with validOut=1 on the next edge (latency 1), and stallOut SHALL remain 0.
REQ-018 IDLE, validIn=1, read or write set, access aligned: the block SHALL latch the inputs, go to REQ, and raise stallOut combinationally in that same cycle.
REQ-019 REQ: memReq=1 with memAddr, memWe, memWData and memByteEn stable SHALL be held until memAck=1.
REQ-020 An ack in the same cycle as the request SHALL be legal.
REQ-021 REQ + memAck: the block SHALL capture the extended load data (or nothing for a store), go to RESP, and drop memReq on the next edge.
REQ-022 RESP: validOut SHALL be 1 for exactly one cycle, stallOut SHALL be 0, and the next state SHALL be IDLE.
REQ-023 A new validIn in RESP SHALL be accepted as it would be in IDLE.
REQ-024 stallOut SHALL equal (state==REQ) OR (IDLE and a memory operation is being accepted).
REQ-025 Load extension: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the lane selected by addr[1:0]; LW SHALL pass the word unchanged.
REQ-026 Store lanes: SB SHALL replicate byte0 to all lanes with memByteEn=1<<addr[1:0]; SH SHALL use 0011 or 1100; SW SHALL use 1111.
REQ-027 memAddr SHALL equal {addr[31:2],2'b00}.
REQ-028 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): the block SHALL issue no request, pulse misalignOut=1 next cycle with validOut=1 and writeEnableOut=0, and stay in IDLE.
REQ-029 read and write both set: the block SHALL treat the operation as a store and ignore the read bit.
REQ-030 writeEnableOut SHALL be 0 for stores, and 0 whenever writeBackAddrIn==0.
REQ-031 Upstream inputs SHALL be ignored while in REQ, because upstream is frozen.
REQ-032 memAck received in IDLE or RESP SHALL be ignored.
REQ-033 When validOut=0, writeEnableOut SHALL be 0 and the other outputs SHALL hold their values.

Reset
REQ-034 On reset the block SHALL enter IDLE and zero every output register (validOut, writeEnableOut, writeBackAddrOut, writeBackData, misalignOut), forcing memReq=0 and stallOut=0 in the following cycle.
REQ-035 Reset asserted in REQ SHALL abandon the transaction, and a memAck arriving after reset SHALL be dropped.

Structure
REQ-036 The shared define file SHALL hold DataSize, RegAddrSize, DataCacheControlBus and the funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101).
REQ-037 The FSM state encoding SHALL be local to this module.
REQ-038 One combinational sub-module, mem_lane_align, SHALL do store lane shifting, byte-enable generation and load extraction/extension.

Verification
REQ-039 ALU op: validIn=1, ctrl=00000, aluResultIn=0x1234, rd=5 -> next cycle validOut=1, writeBackData=0x1234, writeEnableOut=1, stallOut=0 throughout.
REQ-040 LB: addr 0x1003, memRData=0x80FFFFFF, ack after 3 cycles -> stallOut high 4 cycles, memAddr=0x1000, writeBackData=0xFFFFFF80; LBU on the same data -> 0x00000080.
REQ-041 SH: addr 0x2002, storeData=0xABCD -> memByteEn=1100, memWData=0xABCDABCD, memWe=1, writeEnableOut=0.
REQ-042 LW: addr 0x3001 -> memReq never asserted, misalignOut pulses for 1 cycle, writeEnableOut=0.
REQ-043 Back-to-back: LW with ack in the request cycle, then an ALU op presented in RESP -> two consecutive validOut cycles, correct data for each.
REQ-044 Reset in REQ, then memAck=1 the following cycle -> state IDLE, all outputs 0, no validOut pulse.
